// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: fixed AXI IDs per port,
// AR holding-register state encoding and the size-to-arsize mapping.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    function automatic logic [2:0] size_to_arsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_out_cnt.sv
// Per-ID outstanding read counter: saturating up/down, never wraps.
// A simultaneous inc and dec leaves the count unchanged.
module rd_out_cnt #(
    parameter int MAX = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between fetch (ID 0) and load (ID 1) ports.
// Loads have priority; a starvation counter forces fetch through periodically.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int MAX_OUT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               inst_req,
    input  logic [31:0]                        inst_addr,
    input  logic [1:0]                         inst_size,
    output logic                               inst_addr_ok,
    output logic                               inst_data_ok,
    output logic [31:0]                        inst_rdata,
    input  logic                               data_req,
    input  logic [31:0]                        data_addr,
    input  logic [1:0]                         data_size,
    output logic                               data_addr_ok,
    output logic                               data_data_ok,
    output logic [31:0]                        data_rdata,
    input  logic                               wr_pend_valid,
    input  logic [29:0]                        wr_pend_addr,
    output logic [3:0]                         arid,
    output logic [31:0]                        araddr,
    output logic [2:0]                         arsize,
    output logic                               arvalid,
    input  logic                               arready,
    input  logic [3:0]                         rid,
    input  logic [31:0]                        rdata,
    input  logic                               rvalid,
    output logic                               rready,
    output logic                               err_rid,
    output ar_state_t                          dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve,
    output logic [$clog2(MAX_OUT+1)-1:0]       dbg_cnt_inst,
    output logic [$clog2(MAX_OUT+1)-1:0]       dbg_cnt_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    ar_state_t      state, state_next;
    logic [SW-1:0]  starve;
    logic           full_inst, full_data, empty_inst, empty_data;
    logic           r_hs, rid_inst, rid_data, dec_inst, dec_data, bad_beat;
    logic           can_accept, hazard, inst_elig, data_elig;
    logic           grant_inst, grant_data, grant_any;

    assign r_hs     = rvalid && rready;
    assign rid_inst = (rid == ID_INST);
    assign rid_data = (rid == ID_DATA);
    assign dec_inst = r_hs && rid_inst && !empty_inst;
    assign dec_data = r_hs && rid_data && !empty_data;
    assign bad_beat = r_hs && ((!rid_inst && !rid_data) ||
                               (rid_inst && empty_inst) ||
                               (rid_data && empty_data));

    assign can_accept = (state == AR_IDLE) || (state == AR_BUSY && arready);
    assign hazard     = wr_pend_valid && (data_addr[31:2] == wr_pend_addr);

    // A slot freed by an R beat this cycle can be reused by a grant in the same cycle.
    assign inst_elig = inst_req && (!full_inst || dec_inst);
    assign data_elig = data_req && (!full_data || dec_data) && !hazard;

    assign grant_inst = can_accept && inst_elig && (!data_elig || starve == STARVE_MAX);
    assign grant_data = can_accept && data_elig && !grant_inst;
    assign grant_any  = grant_inst || grant_data;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = dec_inst;
    assign data_data_ok = dec_data;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign arvalid      = (state == AR_BUSY);

    assign dbg_state  = state;
    assign dbg_starve = starve;

    rd_out_cnt #(.MAX(MAX_OUT)) u_cnt_inst (
        .clk   (aclk),
        .rst_n (aresetn),
        .inc   (grant_inst),
        .dec   (dec_inst),
        .count (dbg_cnt_inst),
        .full  (full_inst),
        .empty (empty_inst)
    );

    rd_out_cnt #(.MAX(MAX_OUT)) u_cnt_data (
        .clk   (aclk),
        .rst_n (aresetn),
        .inc   (grant_data),
        .dec   (dec_data),
        .count (dbg_cnt_data),
        .full  (full_data),
        .empty (empty_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            AR_IDLE: if (grant_any) state_next = AR_BUSY;
            AR_BUSY: if (arready) state_next = grant_any ? AR_BUSY : AR_IDLE;
            default: state_next = AR_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= AR_IDLE;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
            rready  <= 1'b0;
            starve  <= '0;
            err_rid <= 1'b0;
        end else begin
            state  <= state_next;
            rready <= 1'b1;
            if (grant_any) begin
                arid   <= grant_data ? ID_DATA : ID_INST;
                araddr <= grant_data ? data_addr : inst_addr;
                arsize <= size_to_arsize(grant_data ? data_size : inst_size);
            end
            if (!inst_req || grant_inst) begin
                starve <= '0;
            end else if (inst_elig && can_accept && starve != STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
            if (bad_beat) begin
                err_rid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: stimulus pushes expected AR and R
// transfers into queues, a negedge monitor pops and compares them.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, wr_pend_valid, arready, rvalid;
    logic [31:0] inst_addr, data_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [29:0] wr_pend_addr;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic        arvalid, rready, err_rid;
    ar_state_t   dbg_state;
    logic [2:0]  dbg_starve;
    logic [1:0]  dbg_cnt_inst, dbg_cnt_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [38:0] exp_ar_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];

    axi_rd_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_pend_valid(wr_pend_valid), .wr_pend_addr(wr_pend_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .err_rid(err_rid),
        .dbg_state(dbg_state), .dbg_starve(dbg_starve),
        .dbg_cnt_inst(dbg_cnt_inst), .dbg_cnt_data(dbg_cnt_data)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0;
        data_req = 1'b0;
        rvalid   = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        if (id == ID_INST) exp_inst_q.push_back(d);
        if (id == ID_DATA) exp_data_q.push_back(d);
    endtask

    task automatic exp_ar(input logic [3:0] id, input logic [31:0] a, input logic [2:0] s);
        exp_ar_q.push_back({id, a, s});
    endtask

    // scoreboard monitor
    always @(negedge aclk) begin
        if (aresetn) begin
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", {25'd0, arid, araddr, arsize}, 64'd0);
                else check("ar_beat", {25'd0, arid, araddr, arsize}, {25'd0, exp_ar_q.pop_front()});
            end
            if (inst_data_ok) begin
                if (exp_inst_q.size() == 0) check("inst_r_unexpected", {32'd0, inst_rdata}, 64'hdead);
                else check("inst_rdata", {32'd0, inst_rdata}, {32'd0, exp_inst_q.pop_front()});
            end
            if (data_data_ok) begin
                if (exp_data_q.size() == 0) check("data_r_unexpected", {32'd0, data_rdata}, 64'hdead);
                else check("data_rdata", {32'd0, data_rdata}, {32'd0, exp_data_q.pop_front()});
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        inst_addr = '0; inst_size = 2'd2; data_addr = '0; data_size = 2'd2;
        wr_pend_valid = 1'b0; wr_pend_addr = '0; arready = 1'b1;
        rid = '0; rdata = '0;
        idle_inputs();
        step(); step();
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_state", dbg_state, AR_IDLE);
        check("rst_arid_araddr", {arid, araddr, arsize}, 0);
        check("rst_cnts", {dbg_cnt_inst, dbg_cnt_data, dbg_starve}, 0);
        check("rst_err", err_rid, 0);
        aresetn = 1'b1;
        step();
        check("rready_up", rready, 1);

        // both ports request: data wins
        step();
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_addr = 32'h0000_2000;
        settle();
        check("prio_data_ok", data_addr_ok, 1);
        check("prio_inst_ok", inst_addr_ok, 0);
        exp_ar(ID_DATA, 32'h0000_2000, 3'd2);
        step();
        idle_inputs();
        settle();
        check("prio_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h0000_2000});
        step();
        r_beat(ID_DATA, 32'h0000_00D1);
        settle();
        check("prio_r_route", {inst_data_ok, data_data_ok}, 2'b01);
        step();
        idle_inputs();
        settle();
        check("prio_cnt_data", dbg_cnt_data, 0);
        check("prio_state_idle", dbg_state, AR_IDLE);

        // starvation guard: inst wins on the 5th eligible cycle
        data_addr = 32'h0000_3000;
        inst_addr = 32'h0000_1100;
        for (int k = 1; k <= 5; k++) begin
            step();
            inst_req = 1'b1;
            data_req = 1'b1;
            if (k >= 2) r_beat(ID_DATA, 32'h100 + k);
            else rvalid = 1'b0;
            settle();
            check("starve_cnt", dbg_starve, k - 1);
            if (k < 5) begin
                check("starve_data_win", {data_addr_ok, inst_addr_ok}, 2'b10);
                exp_ar(ID_DATA, 32'h0000_3000, 3'd2);
            end else begin
                check("starve_inst_win", {data_addr_ok, inst_addr_ok}, 2'b01);
                exp_ar(ID_INST, 32'h0000_1100, 3'd2);
            end
        end
        step();
        idle_inputs();
        settle();
        check("starve_cleared", dbg_starve, 0);
        check("starve_cnts", {dbg_cnt_inst, dbg_cnt_data}, {2'd1, 2'd0});
        step();
        r_beat(ID_INST, 32'h0000_00A5);
        settle();
        check("starve_inst_r", {inst_data_ok, data_data_ok}, 2'b10);
        step();
        idle_inputs();

        // outstanding limit on fetch
        for (int k = 0; k < 3; k++) begin
            step();
            inst_req  = 1'b1;
            inst_addr = 32'h0000_4000 + 32'(4 * k);
            settle();
            if (k < 2) begin
                check("max_out_grant", inst_addr_ok, 1);
                exp_ar(ID_INST, inst_addr, 3'd2);
            end else begin
                check("max_out_block", inst_addr_ok, 0);
            end
        end
        check("max_out_cnt", dbg_cnt_inst, 2);
        step();
        r_beat(ID_INST, 32'h0000_00B0);
        settle();
        check("max_out_free_grant", {inst_addr_ok, inst_data_ok}, 2'b11);
        exp_ar(ID_INST, 32'h0000_4008, 3'd2);
        step();
        idle_inputs();
        settle();
        check("max_out_cnt_hold", dbg_cnt_inst, 2);
        step(); r_beat(ID_INST, 32'h0000_00B1);
        step(); r_beat(ID_INST, 32'h0000_00B2);
        step(); idle_inputs();
        settle();
        check("max_out_drained", dbg_cnt_inst, 0);

        // read-after-write hazard on a pending store word
        step();
        data_req = 1'b1; data_addr = 32'h0001_C008; data_size = 2'd1;
        wr_pend_valid = 1'b1; wr_pend_addr = 30'h0000_7002;
        settle();
        check("raw_block_0", data_addr_ok, 0);
        step();
        settle();
        check("raw_block_1", data_addr_ok, 0);
        step();
        wr_pend_valid = 1'b0;
        settle();
        check("raw_release", data_addr_ok, 1);
        exp_ar(ID_DATA, 32'h0001_C008, 3'd1);
        step();
        idle_inputs();
        step(); r_beat(ID_DATA, 32'h0000_00C0);
        step(); idle_inputs();

        // AR stall with arready low, then back-to-back handshakes
        step();
        arready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_5000; inst_size = 2'd0;
        settle();
        check("stall_grant", inst_addr_ok, 1);
        exp_ar(ID_INST, 32'h0000_5000, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            inst_req = 1'b0;
            settle();
            check("stall_hold", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h0000_5000, 3'd0});
        end
        step();
        arready = 1'b1;
        data_req = 1'b1; data_addr = 32'h0000_6000; data_size = 2'd2;
        settle();
        check("b2b_grant_data", data_addr_ok, 1);
        exp_ar(ID_DATA, 32'h0000_6000, 3'd2);
        step();
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_5004; inst_size = 2'd2;
        settle();
        check("b2b_ar_data", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h0000_6000});
        check("b2b_grant_inst", inst_addr_ok, 1);
        exp_ar(ID_INST, 32'h0000_5004, 3'd2);
        step();
        idle_inputs();
        settle();
        check("b2b_ar_inst", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h0000_5004});
        step(); r_beat(ID_DATA, 32'h0000_00E1);
        step(); r_beat(ID_INST, 32'h0000_00E0);
        step(); r_beat(ID_INST, 32'h0000_00E2);
        step(); idle_inputs();
        settle();
        check("b2b_idle", {dbg_state, dbg_cnt_inst, dbg_cnt_data}, {AR_IDLE, 2'd0, 2'd0});

        // bad R beats
        step();
        rvalid = 1'b1; rid = 4'd2; rdata = 32'h0000_0BAD;
        settle();
        check("bad_rid_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
        step();
        rid = ID_INST;
        settle();
        check("err_rid_set", err_rid, 1);
        check("empty_rid_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
        step();
        rvalid = 1'b0;
        settle();
        check("err_cnts_no_underflow", {dbg_cnt_inst, dbg_cnt_data}, 0);

        // reset mid-transaction
        arready = 1'b0;
        step();
        inst_req = 1'b1; inst_addr = 32'h0000_7000;
        step();
        inst_req = 1'b0;
        settle();
        check("pre_rst_held", {arvalid, dbg_cnt_inst}, {1'b1, 2'd1});
        step();
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        settle();
        check("mid_rst_err", err_rid, 0);
        check("mid_rst_ar", {arvalid, dbg_state}, {1'b0, AR_IDLE});
        check("mid_rst_cnts", {dbg_cnt_inst, dbg_cnt_data, dbg_starve}, 0);
        step();
        settle();
        check("mid_rst_rready", rready, 1);

        check("ar_queue_empty", exp_ar_q.size(), 0);
        check("inst_queue_empty", exp_inst_q.size(), 0);
        check("data_queue_empty", exp_data_q.size(), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read-address and read-data channels between the instruction fetch port (AXI ID 0) and the data load port (AXI ID 1).
- Both ports use the sram-like req/addr_ok/data_ok protocol.
- Data port has priority, with a starvation guard for fetch.
- Tracks outstanding reads per ID, routes R beats back by rid, and holds data loads that hit a pending store word (read-after-write hazard).

Parameters:
- MAX_OUT, 2: maximum outstanding reads per ID, counted from addr_ok to R handshake.
- STARVE_LIMIT, 4: consecutive cycles fetch may lose arbitration before it is forced to win.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch read request
- inst_addr  in  32  fetch address
- inst_size  in  2  fetch size (0=byte, 1=half, 2=word)
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load request
- data_addr  in  32  load address
- data_size  in  2  load size
- data_addr_ok  out  1  load request accepted
- data_data_ok  out  1  load data valid
- data_rdata  out  32  load data
- wr_pend_valid  in  1  a store is pending in the write path
- wr_pend_addr  in  30  word address [31:2] of the pending store
- arid  out  4  read ID
- araddr  out  32  read address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R ID
- rdata  in  32  R data
- rvalid  in  1  R valid
- rready  out  1  R ready
- err_rid  out  1  sticky: R beat arrived with an unknown rid or with no outstanding read for that ID

Behaviour:
- Clocking: one clock aclk. Reset aresetn is synchronous and active-low.
- Reset values: arvalid=0, rready=0, state=AR_IDLE, arid/araddr/arsize=0, both outstanding counters=0, starve counter=0, err_rid=0.
- Reset mid-transaction: in-flight reads are dropped; the downstream slave is reset alongside.
- rready: 1 in every cycle after reset is deasserted.
- FSM states:
  - AR_IDLE: AR holding register empty.
  - AR_BUSY: arvalid=1, holding register stable until arready.
- can_accept: (state==AR_IDLE) || (state==AR_BUSY && arready). Pipelined: a new grant may load the holding register in the same cycle as the AR handshake.
- Eligibility:
  - inst_elig = inst_req && cnt0 < MAX_OUT.
  - data_elig = data_req && cnt1 < MAX_OUT && !(wr_pend_valid && data_addr[31:2]==wr_pend_addr).
- Grant: data wins unless starve == STARVE_LIMIT, in which case inst wins.
- Starve counter:
  - Increments (saturating) each cycle inst_elig && can_accept && inst not granted.
  - Clears on any inst grant, or when inst_req is low.
- addr_ok: combinational, asserted only for the granted port when can_accept. The never-granted port sees addr_ok=0.
- Grant timing: grant at cycle T; arvalid, arid, araddr and arsize register at T+1; state becomes AR_BUSY.
- AR handshake with no new grant: state returns to AR_IDLE.
- Outstanding counters (width clog2(MAX_OUT+1)):
  - Increment on grant (addr_ok) for that ID.
  - Decrement on R handshake (rvalid && rready) with a matching rid.
  - Both events in the same cycle: count unchanged.
  - Counters never wrap.
- Routing:
  - inst_data_ok = rvalid && rready && rid==0; data_data_ok likewise for rid==1.
  - rdata is fanned to both *_rdata ports unmodified (same cycle, zero latency).
- Ordering: the AXI slave returns same-ID reads in order. No reorder buffer is required; cross-ID interleaving is allowed.
- err_rid: set on an R beat with rid not in {0,1}, or with the matching counter at 0. Such a beat is otherwise ignored, and the counter does not underflow. Cleared only by reset.
- Both ports ineligible: no grant; a held AR is unaffected.

Decomposition:
- Shared package (mycpu header): ID_INST=4'd0, ID_DATA=4'd1, AR_IDLE/AR_BUSY state encoding, size-to-arsize mapping.
- Sub-module: rd_out_cnt. Parameterised up/down saturating counter with inc, dec and a "full" output; instantiated once per ID.

Test Plan:
- Both requesting in the same cycle, counters 0, no store pending, arready=1 → data_addr_ok=1, inst_addr_ok=0; next cycle arvalid=1, arid=1, araddr=data_addr.
- data_req held high with inst_req high, STARVE_LIMIT=4 → inst is granted on the 5th eligible cycle; starve counter reads 0 afterwards.
- Three inst reads with MAX_OUT=2 and rvalid held low → third inst_addr_ok stays 0; one R beat with rid=0 → grant occurs in that same cycle.
- data_addr=0x1C008, wr_pend_valid=1, wr_pend_addr=0x07002 → no data_addr_ok; wr_pend_valid drops → data_addr_ok=1 the same cycle.
- arready held low for 3 cycles → araddr, arid and arsize stable and arvalid=1 throughout; with arready=1 plus a new request, back-to-back AR handshakes on consecutive cycles.
- R beat with rid=2, then rid=0 with cnt0=0 → err_rid=1, no data_ok pulses; aresetn=0 for one cycle → err_rid=0, arvalid=0, counters 0.
